// File: rtl/claw_pkg.sv
// ---------------------------------------------------------------------------
// claw_pkg
//   Shared definitions for the claw command scheduler: servo command codes,
//   scheduler FSM state encoding and a small helper for sizing counters.
//   No ports (package).
// ---------------------------------------------------------------------------
package claw_pkg;

  // Servo controller ctrl codes.
  localparam logic [1:0] CLAW_OFF     = 2'b00;
  localparam logic [1:0] CLAW_OPEN    = 2'b01;
  localparam logic [1:0] CLAW_CLOSE   = 2'b10;
  localparam logic [1:0] CLAW_NEUTRAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARM         = 3'd1,
    ST_WAIT_STATIC = 3'd2,
    ST_SETTLE      = 3'd3,
    ST_DONE        = 3'd4
  } claw_state_e;

  function automatic int claw_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/claw_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// claw_cmd_scheduler_if
//   Bundles the two requester handshakes, the servo controller link and the
//   status outputs of the claw scheduler.
//   slave  : scheduler side (consumes requests/static, drives grants/servo)
//   master : environment side (requesters, servo controller, status reader)
// ---------------------------------------------------------------------------
interface claw_cmd_scheduler_if;

  logic       req_a;
  logic [1:0] cmd_a;
  logic       grant_a;
  logic       req_b;
  logic [1:0] cmd_b;
  logic       grant_b;
  logic [1:0] servo_ctrl;
  logic       servo_static;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       owner;

  modport slave (
    input  req_a, cmd_a, req_b, cmd_b, servo_static,
    output grant_a, grant_b, servo_ctrl, busy, done, err_timeout, owner
  );

  modport master (
    output req_a, cmd_a, req_b, cmd_b, servo_static,
    input  grant_a, grant_b, servo_ctrl, busy, done, err_timeout, owner
  );

endinterface

// File: rtl/claw_timer.sv
// ---------------------------------------------------------------------------
// claw_timer
//   Loadable saturating up-counter with a terminal-value compare.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (count -> 0)
//     load          load load_value this edge (has priority over en)
//     load_value    value to load
//     en            count up by one (sticks at all-ones, never wraps)
//     terminal      compare value
//     at_terminal   current count equals terminal
// ---------------------------------------------------------------------------
module claw_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign at_terminal = (count_reg == terminal);

endmodule

// File: rtl/claw_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// claw_cmd_scheduler
//   Shares the claw servo controller between requester A (autonomous) and
//   requester B (manual). Round-robin grant, drives servo ctrl, waits for the
//   servo's static flag (with timeout), holds a mechanical settle time, then
//   pulses done (err_timeout valid with it).
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset; aborts any command, ctrl -> off
//     bus   claw_cmd_scheduler_if.slave: req/cmd/grant for A and B,
//           servo_ctrl/servo_static, busy, done, err_timeout, owner
//   Optional feature: define CLAW_IDLE_OFF_EN to power the servo off after
//   IDLE_OFF_CYCLES consecutive idle cycles.
// ---------------------------------------------------------------------------
module claw_cmd_scheduler
  import claw_pkg::*;
#(
  parameter int ARM_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES  = 4_000_000,
  parameter int SETTLE_CYCLES   = 2_000_000,
  parameter int IDLE_OFF_CYCLES = 500_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  claw_cmd_scheduler_if.slave   bus
);

  localparam int TW = $clog2(claw_max3(ARM_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES) + 1);

  // The state timer reads 0 during the grant cycle. ARM therefore spans the
  // grant cycle plus ARM_CYCLES cycles in which static is not trusted; the
  // timeout and settle compares use N-1 so the exit lands on cycle N.
  localparam logic [TW-1:0] ARM_T     = TW'(ARM_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_T  = TW'(SETTLE_CYCLES - 1);

  claw_state_e state_reg, state_next;
  logic [1:0]  servo_reg, servo_next;
  logic        grant_a_reg, grant_a_next;
  logic        grant_b_reg, grant_b_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;   // 1 = B was granted last
  logic        err_reg, err_next;

  logic          tmr_load;
  logic [TW-1:0] tmr_term;
  logic          tmr_hit;
  logic          idle_expired;

  claw_timer #(.WIDTH(TW)) u_state_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (tmr_load),
    .load_value  ('0),
    .en          (1'b1),
    .terminal    (tmr_term),
    .at_terminal (tmr_hit)
  );

`ifdef CLAW_IDLE_OFF_EN
  localparam int IW = $clog2(IDLE_OFF_CYCLES + 1);

  // Held at zero outside IDLE, so every grant restarts the idle count.
  claw_timer #(.WIDTH(IW)) u_idle_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (state_reg != ST_IDLE),
    .load_value  ('0),
    .en          (state_reg == ST_IDLE),
    .terminal    (IW'(IDLE_OFF_CYCLES - 1)),
    .at_terminal (idle_expired)
  );
`else
  logic unused_idle_off;
  assign unused_idle_off = ^IDLE_OFF_CYCLES;
  assign idle_expired    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      servo_reg   <= CLAW_OFF;
      grant_a_reg <= 1'b0;
      grant_b_reg <= 1'b0;
      owner_reg   <= 1'b0;
      last_reg    <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      servo_reg   <= servo_next;
      grant_a_reg <= grant_a_next;
      grant_b_reg <= grant_b_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    servo_next   = servo_reg;
    grant_a_next = 1'b0;
    grant_b_next = 1'b0;
    owner_next   = owner_reg;
    last_next    = last_reg;
    err_next     = err_reg;
    tmr_load     = 1'b0;
    tmr_term     = ARM_T;

    case (state_reg)
      ST_IDLE: begin
        // A wins unless B also asks and A was served last.
        if (bus.req_a && (!bus.req_b || last_reg)) begin
          grant_a_next = 1'b1;
          servo_next   = bus.cmd_a;
          owner_next   = 1'b0;
          last_next    = 1'b0;
          err_next     = 1'b0;
          tmr_load     = 1'b1;
          state_next   = ST_ARM;
        end else if (bus.req_b) begin
          grant_b_next = 1'b1;
          servo_next   = bus.cmd_b;
          owner_next   = 1'b1;
          last_next    = 1'b1;
          err_next     = 1'b0;
          tmr_load     = 1'b1;
          state_next   = ST_ARM;
        end else if (idle_expired && (servo_reg != CLAW_OFF)) begin
          servo_next = CLAW_OFF;
        end
      end

      ST_ARM: begin
        tmr_term = ARM_T;
        if (tmr_hit) begin
          // Off never reports static, so skip the wait entirely.
          state_next = (servo_reg == CLAW_OFF) ? ST_DONE : ST_WAIT_STATIC;
        end
      end

      ST_WAIT_STATIC: begin
        tmr_term = TIMEOUT_T;
        if (bus.servo_static) begin
          tmr_load   = 1'b1;
          state_next = ST_SETTLE;
        end else if (tmr_hit) begin
          // Stalled servo: cut drive to protect it.
          servo_next = CLAW_OFF;
          err_next   = 1'b1;
          state_next = ST_DONE;
        end
      end

      ST_SETTLE: begin
        tmr_term = SETTLE_T;
        if (tmr_hit) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.grant_a     = grant_a_reg;
  assign bus.grant_b     = grant_b_reg;
  assign bus.servo_ctrl  = servo_reg;
  assign bus.owner       = owner_reg;
  assign bus.err_timeout = err_reg;
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_claw_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_claw_cmd_scheduler
//   Directed bench for claw_cmd_scheduler with small timing parameters
//   (ARM=2, TIMEOUT=100, SETTLE=10, IDLE_OFF=50). Expected latencies are
//   hand-computed from the grant edge.
// ---------------------------------------------------------------------------
module tb_claw_cmd_scheduler;
  import claw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  claw_cmd_scheduler_if bus();

  claw_cmd_scheduler #(
    .ARM_CYCLES      (2),
    .TIMEOUT_CYCLES  (100),
    .SETTLE_CYCLES   (10),
    .IDLE_OFF_CYCLES (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output int n, output logic ga, output logic gb);
    n  = 0;
    ga = 1'b0;
    gb = 1'b0;
    while (n < limit && !ga && !gb) begin
      step();
      n++;
      ga = bus.grant_a;
      gb = bus.grant_b;
    end
  endtask

  task automatic wait_done(input int limit, output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      step();
      n++;
      seen = bus.done;
    end
  endtask

  initial begin
    int   n;
    logic ga, gb, sd;

    bus.req_a = 1'b0;
    bus.cmd_a = CLAW_OFF;
    bus.req_b = 1'b0;
    bus.cmd_b = CLAW_OFF;
    bus.servo_static = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    check("rst_servo",   bus.servo_ctrl, 0);
    check("rst_grant_a", bus.grant_a, 0);
    check("rst_grant_b", bus.grant_b, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_err",     bus.err_timeout, 0);
    check("rst_owner",   bus.owner, 0);

    // T1: A closes, static arrives 5 cycles after grant.
    rst = 1'b0;
    bus.req_a = 1'b1;
    bus.cmd_a = CLAW_CLOSE;
    wait_grant(5, n, ga, gb);
    check("t1_grant_a",   ga, 1);
    check("t1_grant_lat", n, 1);
    check("t1_servo",     bus.servo_ctrl, 2);
    check("t1_owner",     bus.owner, 0);
    check("t1_busy",      bus.busy, 1);
    bus.req_a = 1'b0;
    step();
    check("t1_grant_pulse", bus.grant_a, 0);
    repeat (4) step();
    bus.servo_static = 1'b1;
    wait_done(200, n, sd);
    check("t1_done_seen", sd, 1);
    check("t1_latency",   5 + n, 16);
    check("t1_err",       bus.err_timeout, 0);
    $display("txn t1 owner=A cmd=10 latency=%0d err=%0d", 5 + n, bus.err_timeout);
    step();
    check("t1_done_pulse", bus.done, 0);
    check("t1_busy_after", bus.busy, 0);
    check("t1_servo_hold", bus.servo_ctrl, 2);

    // Idle behaviour after done.
`ifdef CLAW_IDLE_OFF_EN
    repeat (44) step();
    check("idle_before_off", bus.servo_ctrl, 2);
    repeat (10) step();
    check("idle_off", bus.servo_ctrl, 0);
    $display("txn idle-off servo=%0d", bus.servo_ctrl);
`else
    repeat (1000) step();
    check("idle_hold", bus.servo_ctrl, 2);
    $display("txn idle-hold servo=%0d", bus.servo_ctrl);
`endif

    // T3: B neutral, static never comes -> timeout.
    bus.servo_static = 1'b0;
    bus.req_b = 1'b1;
    bus.cmd_b = CLAW_NEUTRAL;
    wait_grant(5, n, ga, gb);
    check("t3_grant_b", gb, 1);
    check("t3_grant_a", ga, 0);
    check("t3_owner",   bus.owner, 1);
    check("t3_servo",   bus.servo_ctrl, 3);
    bus.req_b = 1'b0;
    wait_done(300, n, sd);
    check("t3_done_seen", sd, 1);
    check("t3_latency",   n, 100);
    check("t3_servo_off", bus.servo_ctrl, 0);
    check("t3_err",       bus.err_timeout, 1);
    $display("txn t3 owner=B cmd=11 latency=%0d err=%0d", n, bus.err_timeout);
    step();
    check("t3_err_held", bus.err_timeout, 1);
    check("t3_done_low", bus.done, 0);

    // T4: both request, twice -> A then B.
    bus.servo_static = 1'b1;
    bus.req_a = 1'b1;
    bus.cmd_a = CLAW_OPEN;
    bus.req_b = 1'b1;
    bus.cmd_b = CLAW_CLOSE;
    wait_grant(5, n, ga, gb);
    check("t4a_grant_a", ga, 1);
    check("t4a_grant_b", gb, 0);
    check("t4a_owner",   bus.owner, 0);
    check("t4a_err_clr", bus.err_timeout, 0);
    check("t4a_servo",   bus.servo_ctrl, 1);
    bus.req_a = 1'b0;
    wait_done(200, n, sd);
    check("t4a_latency", n, 14);
    $display("txn t4a owner=A cmd=01 latency=%0d err=%0d", n, bus.err_timeout);
    wait_grant(10, n, ga, gb);
    check("t4b_grant_b",   gb, 1);
    check("t4b_grant_lat", n, 2);
    check("t4b_owner",     bus.owner, 1);
    check("t4b_servo",     bus.servo_ctrl, 2);
    bus.req_b = 1'b0;
    wait_done(200, n, sd);
    check("t4b_latency", n, 14);
    $display("txn t4b owner=B cmd=10 latency=%0d err=%0d", n, bus.err_timeout);

    // T5: A off -> skips the static wait.
    bus.servo_static = 1'b0;
    bus.req_a = 1'b1;
    bus.cmd_a = CLAW_OFF;
    wait_grant(5, n, ga, gb);
    check("t5_grant_a", ga, 1);
    check("t5_servo",   bus.servo_ctrl, 0);
    bus.req_a = 1'b0;
    wait_done(200, n, sd);
    check("t5_latency", n, 3);
    check("t5_err",     bus.err_timeout, 0);
    $display("txn t5 owner=A cmd=00 latency=%0d err=%0d", n, bus.err_timeout);

    // T6: reset during SETTLE aborts without done.
    bus.servo_static = 1'b1;
    bus.req_a = 1'b1;
    bus.cmd_a = CLAW_CLOSE;
    wait_grant(5, n, ga, gb);
    check("t6_grant_a", ga, 1);
    bus.req_a = 1'b0;
    repeat (8) step();
    check("t6_in_settle", bus.busy, 1);
    rst = 1'b1;
    step();
    check("t6_rst_servo", bus.servo_ctrl, 0);
    check("t6_rst_busy",  bus.busy, 0);
    check("t6_rst_done",  bus.done, 0);
    rst = 1'b0;
    sd = 1'b0;
    repeat (20) begin
      step();
      if (bus.done) sd = 1'b1;
    end
    check("t6_no_done", sd, 0);
    bus.req_b = 1'b1;
    bus.cmd_b = CLAW_OPEN;
    wait_grant(5, n, ga, gb);
    check("t6_regrant_b", gb, 1);
    check("t6_owner",     bus.owner, 1);
    check("t6_servo",     bus.servo_ctrl, 1);
    bus.req_b = 1'b0;
    wait_done(200, n, sd);
    check("t6_latency", n, 14);
    $display("txn t6 owner=B cmd=01 latency=%0d err=%0d", n, bus.err_timeout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
